// File: rtl/otter_ctrl_pkg.sv
// rtl/otter_ctrl_pkg.sv - shared state and PC-select encodings for the OTTER pipeline sequencer
package otter_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        TRAP  = 2'd3
    } ctrl_state_t;

    localparam logic [2:0] PC_SRC_NPC    = 3'd0;
    localparam logic [2:0] PC_SRC_JALR   = 3'd1;
    localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
    localparam logic [2:0] PC_SRC_JAL    = 3'd3;
    localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
    localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an ID instruction that reads the destination of a load still in EX
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_valid,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 never carries a real value, so a load targeting it cannot create a dependency
    assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall, flush, redirect and interrupt-entry sequencer for the OTTER pipe
module pipeline_hazard_ctrl
    import otter_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [31:0] id_pc,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memRead2,
    input  logic        ex_valid,
    input  logic [2:0]  ex_pc_source,
    input  logic        intr_req,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [2:0]  pc_source,
    output logic        int_taken,
    output logic [31:0] mepc_capture,
    output logic [1:0]  ctrl_state
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] drain_cnt;
    logic             load_use;
    logic             redirect;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_memRead2),
        .ex_valid    (ex_valid),
        .hazard      (load_use)
    );

    assign redirect   = ex_valid && (ex_pc_source != PC_SRC_NPC);
    assign ctrl_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= RUN;
            drain_cnt    <= '0;
            mepc_capture <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    // redirect outranks the stall (ID is wrong-path) and both outrank interrupts
                    if (redirect) begin
                        state <= FLUSH;
                    end else if (!load_use && intr_req) begin
                        mepc_capture <= id_pc;
                        drain_cnt    <= DRAIN_LOAD;
                        state        <= DRAIN;
                    end
                end
                FLUSH: state <= RUN;
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= TRAP;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                TRAP:    state <= FLUSH;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_source   = PC_SRC_NPC;
        int_taken   = 1'b0;
        if (RST) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        pc_source   = ex_pc_source;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush = 1'b1;
                    end else if (intr_req) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                FLUSH: begin
                    // squashes the stale word still leaving the synchronous instruction memory
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                DRAIN: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                TRAP: begin
                    pc_source   = PC_SRC_MTVEC;
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    int_taken   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl against a schedule model
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_N = 2;
    localparam int K_RUN   = 0;
    localparam int K_FLUSH = 1;
    localparam int K_DRAIN = 2;
    localparam int K_TRAP  = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic [31:0] id_pc = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_memRead2 = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_pc_source = '0;
    logic        intr_req = 1'b0;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [2:0]  pc_source;
    logic        int_taken;
    logic [31:0] mepc_capture;
    logic [1:0]  ctrl_state;

    int          tests = 0;
    int          fails = 0;
    int          sched[$];
    logic [31:0] m_mepc = '0;
    int          m_int_count = 0;
    int          dut_int_count = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_N), .CNT_W(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_pc        (id_pc),
        .ex_rd        (ex_rd),
        .ex_memRead2  (ex_memRead2),
        .ex_valid     (ex_valid),
        .ex_pc_source (ex_pc_source),
        .intr_req     (intr_req),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .pc_source    (pc_source),
        .int_taken    (int_taken),
        .mepc_capture (mepc_capture),
        .ctrl_state   (ctrl_state)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (!RST && int_taken) dut_int_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".pc_write"}, 32'(pc_write), 0);
        chk({tag, ".if_id_write"}, 32'(if_id_write), 0);
        chk({tag, ".if_id_flush"}, 32'(if_id_flush), 1);
        chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 1);
        chk({tag, ".pc_source"}, 32'(pc_source), 0);
        chk({tag, ".int_taken"}, 32'(int_taken), 0);
        chk({tag, ".ctrl_state"}, 32'(ctrl_state), 0);
        chk({tag, ".mepc"}, mepc_capture, 0);
    endtask

    // Called just after a falling edge: drive one cycle of inputs, check, advance the model.
    task automatic step(input string tag, input logic v, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [2:0] src, input logic intr, input logic [31:0] pc);
        int  kind;
        bit  hz;
        bit  redir;
        bit  e_pcw;
        bit  e_iff;
        bit  e_ief;
        bit  e_int;
        int  e_src;
        int  e_ifw;
        ex_valid = v; ex_memRead2 = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_pc_source = src; intr_req = intr; id_pc = pc;
        #1;
        kind  = (sched.size() > 0) ? sched[0] : K_RUN;
        hz    = v && mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        redir = v && src != 0;
        e_pcw = 0; e_iff = 1; e_ief = 1; e_int = 0; e_src = 0; e_ifw = -1;
        if (kind == K_FLUSH) e_pcw = 1;
        else if (kind == K_TRAP) begin e_pcw = 1; e_src = 4; e_int = 1; end
        else if (kind == K_RUN) begin
            if (redir) begin e_pcw = 1; e_src = int'(src); end
            else if (hz) begin e_iff = 0; e_ifw = 0; end
            else if (!intr) begin e_pcw = 1; e_iff = 0; e_ief = 0; e_ifw = 1; end
        end
        chk({tag, ".ctrl_state"}, 32'(ctrl_state), 32'(kind));
        chk({tag, ".pc_write"}, 32'(pc_write), 32'(e_pcw));
        chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_iff));
        chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_ief));
        chk({tag, ".pc_source"}, 32'(pc_source), 32'(e_src));
        chk({tag, ".int_taken"}, 32'(int_taken), 32'(e_int));
        chk({tag, ".mepc"}, mepc_capture, m_mepc);
        if (e_ifw >= 0) chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(e_ifw));
        if (e_int) m_int_count++;
        if (sched.size() > 0) void'(sched.pop_front());
        else if (redir) sched.push_back(K_FLUSH);
        else if (!hz && intr) begin
            m_mepc = pc;
            for (int i = 0; i < DRAIN_N; i++) sched.push_back(K_DRAIN);
            sched.push_back(K_TRAP);
            sched.push_back(K_FLUSH);
        end
        @(negedge CLK);
    endtask

    initial begin
        #2;
        chk_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
        step("lu_stall", 1, 1, 5, 1, 5, 1, 1, 0, 0, 32'h104);
        step("lu_after", 1, 0, 6, 1, 5, 1, 1, 0, 0, 32'h108);
        step("lu_x0", 1, 1, 0, 0, 0, 1, 1, 0, 0, 32'h10c);
        step("br", 1, 0, 3, 0, 0, 0, 0, 2, 0, 32'h110);
        step("br_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200);
        step("br_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h204);
        step("redir_lu", 1, 1, 7, 7, 0, 1, 0, 3, 0, 32'h208);
        step("redir_lu_fl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300);

        step("intr_acc", 1, 0, 2, 0, 0, 0, 0, 0, 1, 32'h124);
        step("intr_drain0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h128);
        step("intr_drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h128);
        step("intr_trap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h128);
        step("intr_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400);
        step("intr_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h404);
        chk("mepc_124", mepc_capture, 32'h124);

        step("intr_redir", 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h500);
        step("intr_redir_fl", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h504);
        step("intr_redir_acc", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h600);
        for (int i = 0; i < DRAIN_N + 3; i++)
            step("intr_redir_seq", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h700);
        step("mret", 1, 0, 0, 0, 0, 0, 0, 5, 0, 32'h704);
        step("mret_fl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h600);

        step("rst_acc", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h800);
        step("rst_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h804);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        sched.delete();
        m_mepc = '0;
        @(negedge CLK);
        chk_reset_outputs("rst_held");
        RST = 1'b0;
        for (int i = 0; i < 4; i++)
            step("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h900);

        for (int i = 0; i < 600; i++) begin
            logic [4:0] pick [3];
            logic [2:0] src;
            pick[0] = 5'd0; pick[1] = 5'd5; pick[2] = 5'd7;
            src = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 pick[$urandom_range(0, 2)], pick[$urandom_range(0, 2)], pick[$urandom_range(0, 2)],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), src,
                 $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC);
        end
        chk("int_pulse_count", 32'(dut_int_count), 32'(m_int_count));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
